// File: rtl/vecmat_reduce_acc_32_pkg.sv
// rtl/vecmat_reduce_acc_32_pkg.sv - shared constants, state enum and helpers for the reduce/accumulate block
//
// Purpose : common definitions for vecmat_reduce_acc_32 and adder_tree_32.
//           Data is two's complement with 12 fraction bits throughout; no rescaling.
// Contents: LANES, DATA_WIDTH, TREE_LAT, TREE_WIDTH, ACC_WIDTH constants,
//           lane_slice() lane extractor, state_t enum, sat16() output saturation.
package vecmat_reduce_acc_32_pkg;

    localparam int LANES      = 32;
    localparam int DATA_WIDTH = 16;
    localparam int TREE_LAT   = $clog2(LANES);
    // Each tree level grows the sum by one bit, so the root can never overflow.
    localparam int TREE_WIDTH = DATA_WIDTH + TREE_LAT;
    // Accumulator is sized for groups of up to MAX_ROWS beats so it cannot wrap.
    localparam int MAX_ROWS   = 32;
    localparam int ACC_WIDTH  = DATA_WIDTH + TREE_LAT + $clog2(MAX_ROWS);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Lane i of a packed beat lives at bits [i*DATA_WIDTH +: DATA_WIDTH].
    function automatic logic signed [DATA_WIDTH-1:0] lane_slice(
        input logic [LANES*DATA_WIDTH-1:0] data,
        input int unsigned                 idx
    );
        return data[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Clamp a full-width sum to the signed 16-bit output range.
    function automatic logic [DATA_WIDTH-1:0] sat16(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/vecmat_reduce_acc_32_adder_tree.sv
// rtl/vecmat_reduce_acc_32_adder_tree.sv - pipelined LANES-input signed adder tree with valid/last pipe
//
// Purpose : reduces one packed beat of LANES signed lanes to a single sum.
//           The beat is registered on acceptance, then log2(LANES) adder levels
//           follow, so o_sum is valid TREE_LAT edges after the accepting edge.
// Ports   : clk, reset (async, active-high)
//           i_clear  - synchronous discard of every beat in flight (valid pipe only)
//           i_valid  - i_data is a beat to reduce;  i_last - tag carried with the beat
//           i_data   - packed lanes
//           o_valid/o_last/o_sum - root of the tree with its tags
//           o_busy   - any beat in flight
module adder_tree_32
    import vecmat_reduce_acc_32_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic                          i_last,
    input  logic [LANES*DATA_WIDTH-1:0]   i_data,
    output logic                          o_valid,
    output logic                          o_last,
    output logic signed [TREE_WIDTH-1:0]  o_sum,
    output logic                          o_busy
);

    // Heap layout: node n has children 2n and 2n+1, leaves occupy LANES..2*LANES-1,
    // node 1 is the root. All leaves sit at the same depth, so every node register
    // is one pipeline stage and the tree is balanced by construction. Nodes are
    // held at full root width; the upper bits of shallow levels are sign copies.
    logic signed [TREE_WIDTH-1:0] r_node [1:2*LANES-1];
    // Bit 0 pairs with the leaf stage, bit TREE_LAT with the root.
    logic [TREE_LAT:0]            r_vld;
    logic [TREE_LAT:0]            r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 1; n < 2*LANES; n++) begin
                r_node[n] <= '0;
            end
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            // Data moves every cycle; the valid pipe says which stages mean anything.
            for (int i = 0; i < LANES; i++) begin
                r_node[LANES+i] <= TREE_WIDTH'(lane_slice(i_data, i));
            end
            for (int n = 1; n < LANES; n++) begin
                r_node[n] <= r_node[2*n] + r_node[2*n+1];
            end
            if (i_clear) begin
                r_vld  <= '0;
                r_last <= '0;
            end else begin
                r_vld  <= {r_vld[TREE_LAT-1:0],  i_valid};
                r_last <= {r_last[TREE_LAT-1:0], i_valid & i_last};
            end
        end
    end

    assign o_valid = r_vld[TREE_LAT];
    assign o_last  = r_last[TREE_LAT];
    assign o_sum   = r_node[1];
    assign o_busy  = |r_vld;

endmodule

// File: rtl/vecmat_reduce_acc_32.sv
// rtl/vecmat_reduce_acc_32.sv - reduce 32 product lanes per beat and accumulate ROWS beats into one saturated element
//
// Purpose : consumer of the 32-lane elementwise multiplier. Each beat is summed by
//           adder_tree_32, ROWS tree sums are accumulated, and the saturated
//           16-bit result is offered downstream over valid/ready.
// Ports   : clk, reset (async, active-high)
//           in_valid/in_ready/in_data - packed product beats, lane i at in_data[i*16 +: 16]
//           flush                     - synchronous discard of the partial group
//           out_valid/out_ready/out_data - completed saturated sum
//           busy                      - a beat has been accepted and its result not yet delivered
module vecmat_reduce_acc_32
    import vecmat_reduce_acc_32_pkg::*;
#(
    parameter int ROWS = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t                       r_state;
    state_t                       w_next;
    logic [CNT_W-1:0]             r_cnt;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_out_data;

    logic                         w_accept;
    logic                         w_last_beat;
    logic                         w_tree_valid;
    logic                         w_tree_last;
    logic signed [TREE_WIDTH-1:0] w_tree_sum;
    logic                         w_tree_busy;
    logic signed [ACC_WIDTH-1:0]  w_acc_sum;
    logic                         w_final;

    assign in_ready    = (r_state == ACCUM);
    // A beat presented together with flush is dropped.
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_last_beat = (r_cnt == CNT_W'(ROWS - 1));

    adder_tree_32 u_tree (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_valid (w_accept),
        .i_last  (w_last_beat),
        .i_data  (in_data),
        .o_valid (w_tree_valid),
        .o_last  (w_tree_last),
        .o_sum   (w_tree_sum),
        .o_busy  (w_tree_busy)
    );

    assign w_acc_sum = r_acc + ACC_WIDTH'(w_tree_sum);
    // The group's final beat is tagged in the tree, so its sum marks the result.
    assign w_final   = (r_state == DRAIN) && w_tree_valid && w_tree_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && w_last_beat) w_next = DRAIN;
            DRAIN:   if (w_final)                 w_next = HOLD;
            HOLD:    if (out_ready)               w_next = ACCUM;
            default:                              w_next = ACCUM;
        endcase
        if (flush) begin
            w_next = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            end
            // Only the finished sum is saturated; partial sums stay full width.
            if (w_final) begin
                r_out_data  <= sat16(w_acc_sum);
                r_out_valid <= 1'b1;
                r_acc       <= '0;
            end else if (w_tree_valid) begin
                r_acc <= w_acc_sum;
            end
            if ((r_state == HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ACCUM) || (r_cnt != '0) || w_tree_busy;

endmodule
